ysyx_22040127_ifu: RTL
======================

# ysyx_22040127_ifu

Parametrised instruction-fetch unit replacing the single-cycle core's inline PC register and combinational memory read. It issues pipelined fetch requests over a valid/ready bus with variable response latency, buffers returned instructions in an in-order FIFO, and hands them to decode over a valid/ready handshake. It also supports PC redirects (jal/jalr/branch), including discard of stale in-flight responses, and a sticky halt on ebreak.

## Interface
- ADDR_W, 32, PC/address width
- BUS_W, 64, memory data width (32 or 64); instruction = data[31:0] when BUS_W=32, else selected by pc[2]
- DEPTH, 4, instruction FIFO depth and maximum outstanding requests (power of two, ≥2)
- RESET_PC, 32'h8000_0000, first fetch address
- Clock/reset (already decided): one clock; reset is asynchronous and active-low.
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous reset, active-low
- mem_req_valid  out  1  fetch request
- mem_req_ready  in  1  bus accepts request
- mem_req_addr  out  ADDR_W  fetch address, 4-byte aligned
- mem_rsp_valid  in  1  response data valid; in request order, never before its request
- mem_rsp_data  in  BUS_W  response data
- redirect_valid  in  1  one-cycle redirect pulse
- redirect_pc  in  ADDR_W  new PC; bits [1:0] ignored (treated as 0)
- halt_req  in  1  ebreak retired; pulse
- halted  out  1  sticky halt status
- inst_valid  out  1  instruction available
- inst_ready  in  1  decode accepts
- inst  out  32  instruction word
- inst_pc  out  ADDR_W  PC of inst

## Operation
- States: RUN, HALT. Reset enters RUN; halt_req in RUN enters HALT. HALT is left only by reset.
- Counters: fetch_pc (next request), rsp_pc (PC of next kept response), outstanding (0..DEPTH), drop_cnt (0..DEPTH), FIFO count (0..DEPTH).
- Issue: mem_req_valid = RUN && !redirect_valid && !halt_req && (outstanding + count) < DEPTH. mem_req_addr = fetch_pc. On req fire: fetch_pc += 4, outstanding++.
- Response: outstanding-- on every mem_rsp_valid. If drop_cnt>0 (after redirect update) or state is HALT, discard and decrement drop_cnt if >0. Otherwise push {rsp_pc, word} into FIFO; rsp_pc += 4. Word = mem_rsp_data[63:32] if rsp_pc[2] else [31:0] (BUS_W=64).
- Credit rule guarantees the FIFO never overflows; a push while full is an assertion failure.
- Output: inst_valid = FIFO non-empty && RUN. Pop on inst_valid && inst_ready.
- Redirect: fetch_pc <= {redirect_pc[ADDR_W-1:2],2'b00}, rsp_pc likewise; FIFO flushed (flush beats a same-cycle pop and push); drop_cnt <= outstanding + req_fire − rsp_fire. No request is issued in the redirect cycle.
- Halt: FIFO flushed, requests stop, remaining responses absorbed; halted=1. Redirect in HALT is ignored.
- Address arithmetic wraps modulo 2^ADDR_W.
- mem_req_valid may drop without a handshake only in a cycle where redirect_valid or halt_req is high. Otherwise it is held, with mem_req_addr stable, until ready.

## Timing
- Reset values: mem_req_valid=0, mem_req_addr=RESET_PC, inst_valid=0, inst=0-undefined-but-not-X (drive 0 when empty), inst_pc=RESET_PC, halted=0, all counters 0.
- First request is asserted in the first clock after reset deasserts.
- Response-to-inst_valid latency is 1 cycle (registered FIFO, no bypass).
- Redirect-to-first-request latency is 1 cycle. With a zero-wait bus, the first redirected inst is valid 2 cycles after the redirect.
- Sustained throughput is 1 instruction/cycle with a ready bus and decode.
- halt_req → halted high and inst_valid low the next cycle.
- Asynchronous reset mid-transfer clears all state. The bus must be reset together with the IFU.

## Structure
- Package ysyx_22040127_pkg holds: the ifu_state_e enum (RUN, HALT), the RESET_PC default constant, and the instruction width constant (32).
- One sub-module, ysyx_22040127_fifo: a synchronous FIFO with parameters WIDTH=ADDR_W+32 and DEPTH, plus ports push, pop, flush, full, empty and count.
- The IFU top holds the counters, the state register and the issue/drop logic.

## Test plan
- Reset, zero-wait memory, inst_ready=1 → requests 0x80000000, 0x80000004, …; inst_pc matches each request; words alternate between lower and upper halves; one instruction per cycle.
- inst_ready=0 for 10 cycles → at most DEPTH(4) requests outstanding+buffered, no overflow; on release, 4 instructions drain in order.
- Memory latency 3 cycles with 3 outstanding; redirect to 0x80000102 → drop_cnt=3, three stale responses discarded, next inst_pc=0x80000100.
- Redirect in the same cycle as a response and a pop → FIFO empty next cycle, response dropped, drop_cnt equals remaining outstanding.
- halt_req with 2 in flight → halted=1 next cycle, inst_valid stays 0, no further requests, outstanding reaches 0 after responses.
- Reset asserted asynchronously mid-burst → outputs return to reset values immediately; fetch restarts at 0x80000000.

Source files
------------

// File: rtl/ysyx_22040127_pkg.sv
// Shared types and constants for the ysyx_22040127 instruction-fetch unit.
package ysyx_22040127_pkg;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } ifu_state_e;

  localparam logic [31:0] RESET_PC_DEF = 32'h8000_0000;
  localparam int          INST_W       = 32;

endpackage

// File: rtl/ysyx_22040127_fifo.sv
// In-order instruction FIFO: registered output, flush clears everything and wins over push/pop.
module ysyx_22040127_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign w_do_push = push && !flush;
  assign w_do_pop  = pop && !empty && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      r_count <= r_count + CW'(w_do_push) - CW'(w_do_pop);
    end
  end

  // Storage needs no reset: dout is only consumed while the FIFO is non-empty.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr] <= din;
  end

  assign dout  = r_mem[r_rd_ptr];
  assign full  = (r_count == CW'(DEPTH));
  assign empty = (r_count == '0);
  assign count = r_count;

endmodule

// File: rtl/ysyx_22040127_ifu.sv
// Instruction fetch unit: pipelined fetch over a valid/ready bus into an in-order FIFO.
// state | meaning
// RUN   | issuing requests and delivering instructions to decode
// HALT  | ebreak retired; FIFO empty, late responses absorbed, left only by reset
module ysyx_22040127_ifu
  import ysyx_22040127_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter int                BUS_W    = 64,
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEF)
) (
  input  logic              clk,
  input  logic              rst,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [ADDR_W-1:0] mem_req_addr,
  input  logic              mem_rsp_valid,
  input  logic [BUS_W-1:0]  mem_rsp_data,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              halt_req,
  output logic              halted,
  output logic              inst_valid,
  input  logic              inst_ready,
  output logic [INST_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int FW = ADDR_W + INST_W;

  ifu_state_e        r_state;
  ifu_state_e        w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic [ADDR_W-1:0] r_rsp_pc;
  logic [CW-1:0]     r_outstanding;
  logic [CW-1:0]     r_drop_cnt;
  logic [ADDR_W-1:0] w_redir_pc;
  logic [CW-1:0]     w_count;
  logic [CW:0]       w_inflight;
  logic              w_run;
  logic              w_redirect;
  logic              w_req_fire;
  logic              w_keep;
  logic              w_flush;
  logic              w_pop;
  logic              w_full;
  logic              w_empty;
  logic [INST_W-1:0] w_word;
  logic [FW-1:0]     w_fifo_din;
  logic [FW-1:0]     w_fifo_dout;

  assign w_run      = (r_state == RUN);
  assign w_redirect = w_run && redirect_valid && !halt_req;
  assign w_redir_pc = redirect_pc & ~ADDR_W'(3);

  // Credits cover both in-flight requests and buffered words, so a response always has a slot.
  assign w_inflight    = {1'b0, r_outstanding} + {1'b0, w_count};
  assign mem_req_valid = rst && w_run && !redirect_valid && !halt_req
                         && (w_inflight < (CW+1)'(DEPTH));
  assign mem_req_addr  = r_fetch_pc;
  assign w_req_fire    = mem_req_valid && mem_req_ready;

  assign w_keep  = mem_rsp_valid && w_run && !redirect_valid && !halt_req
                   && (r_drop_cnt == '0);
  assign w_flush = w_run && (redirect_valid || halt_req);
  assign w_word  = (BUS_W > INST_W && r_rsp_pc[2]) ? mem_rsp_data[BUS_W-1 -: INST_W]
                                                    : mem_rsp_data[INST_W-1:0];
  assign w_fifo_din = {r_rsp_pc, w_word};

  assign inst_valid = rst && w_run && !w_empty;
  assign w_pop      = inst_valid && inst_ready;
  assign inst       = inst_valid ? w_fifo_dout[INST_W-1:0] : '0;
  assign inst_pc    = inst_valid ? w_fifo_dout[FW-1:INST_W] : RESET_PC;
  assign halted     = (r_state == HALT);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      RUN:     if (halt_req) w_state_nxt = HALT;
      HALT:    w_state_nxt = HALT;
      default: w_state_nxt = RUN;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state       <= RUN;
      r_fetch_pc    <= RESET_PC;
      r_rsp_pc      <= RESET_PC;
      r_outstanding <= '0;
      r_drop_cnt    <= '0;
    end else begin
      r_state       <= w_state_nxt;
      r_outstanding <= r_outstanding + CW'(w_req_fire) - CW'(mem_rsp_valid);
      if (w_redirect) begin
        // Everything still in flight after this cycle belongs to the old path.
        r_fetch_pc <= w_redir_pc;
        r_rsp_pc   <= w_redir_pc;
        r_drop_cnt <= r_outstanding + CW'(w_req_fire) - CW'(mem_rsp_valid);
      end else begin
        if (w_req_fire) r_fetch_pc <= r_fetch_pc + ADDR_W'(4);
        if (w_keep)     r_rsp_pc   <= r_rsp_pc + ADDR_W'(4);
        if (mem_rsp_valid && r_drop_cnt != '0) r_drop_cnt <= r_drop_cnt - CW'(1);
      end
    end
  end

  ysyx_22040127_fifo #(
    .WIDTH (FW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst),
    .push  (w_keep),
    .pop   (w_pop),
    .flush (w_flush),
    .din   (w_fifo_din),
    .dout  (w_fifo_dout),
    .full  (w_full),
    .empty (w_empty),
    .count (w_count)
  );

  a_no_overflow: assert property (@(posedge clk) disable iff (!rst) !(w_keep && w_full));

endmodule
